// File: rtl/item_spawner.sv
// Food item placer: keeps up to NUM_ITEMS slots filled with LFSR-drawn cells that lie
// inside the field, avoid each other and avoid every snake segment of a full body pass.
module item_spawner #(
  parameter int NUM_ITEMS = 4,
  parameter int X_BITS    = 5,
  parameter int Y_BITS    = 4,
  parameter int FIELD_W   = 20,
  parameter int FIELD_H   = 12,
  localparam int IDX_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  localparam int ACT_W    = $clog2(NUM_ITEMS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ACT_W-1:0]              i_active,
  input  logic                          i_entropy,
  input  logic                          i_seg_valid,
  input  logic                          i_seg_first,
  input  logic                          i_seg_last,
  input  logic [X_BITS-1:0]             i_seg_x,
  input  logic [Y_BITS-1:0]             i_seg_y,
  output logic [NUM_ITEMS*X_BITS-1:0]   o_item_x,
  output logic [NUM_ITEMS*Y_BITS-1:0]   o_item_y,
  output logic [NUM_ITEMS-1:0]          o_ready,
  output logic                          o_eat,
  output logic [IDX_W-1:0]              o_eat_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAW  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_TEST  = 3'd4;
  localparam logic [2:0] S_READY = 3'd5;

  // Right-shifting Galois masks of maximal-length polynomials
  function automatic logic [7:0] lfsr_taps(input int w);
    case (w)
      2:       return 8'h03;
      3:       return 8'h06;
      4:       return 8'h0C;
      5:       return 8'h14;
      6:       return 8'h30;
      7:       return 8'h60;
      8:       return 8'hB8;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int gcd(input int a, input int b);
    int p, q, t;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  localparam logic [X_BITS-1:0] TAP_X = X_BITS'(lfsr_taps(X_BITS));
  localparam logic [Y_BITS-1:0] TAP_Y = Y_BITS'(lfsr_taps(Y_BITS));
  localparam logic [X_BITS-1:0] MAX_X = X_BITS'(FIELD_W);
  localparam logic [Y_BITS-1:0] MAX_Y = Y_BITS'(FIELD_H);

  // Coprime periods make the joint (x,y) sequence visit every pair
  if (gcd((1 << X_BITS) - 1, (1 << Y_BITS) - 1) != 1) begin : g_period_check
    $error("item_spawner: LFSR periods are not coprime");
  end
  if (lfsr_taps(X_BITS) == 8'h00 || lfsr_taps(Y_BITS) == 8'h00) begin : g_tap_check
    $error("item_spawner: unsupported LFSR width");
  end

  logic [2:0]          state [NUM_ITEMS];
  logic [X_BITS-1:0]   pos_x [NUM_ITEMS];
  logic [Y_BITS-1:0]   pos_y [NUM_ITEMS];
  logic [X_BITS-1:0]   lfsr_x;
  logic [Y_BITS-1:0]   lfsr_y;
  logic [NUM_ITEMS-1:0] active, grant, placed, hit, reject;
  logic                draw_taken, eat_any, step;
  logic [IDX_W-1:0]    eat_idx;

  always_comb begin
    grant      = '0;
    draw_taken = 1'b0;
    eat_any    = 1'b0;
    eat_idx    = '0;
    for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
      active[k] = (32'(i_active) > k);
      placed[k] = active[k] && (state[k] == S_CHECK || state[k] == S_WAIT ||
                                state[k] == S_TEST  || state[k] == S_READY);
      hit[k]    = i_seg_valid && (i_seg_x == pos_x[k]) && (i_seg_y == pos_y[k]);
      if (!draw_taken && active[k] && state[k] == S_DRAW) begin
        grant[k]   = 1'b1;
        draw_taken = 1'b1;
      end
      if (active[k] && state[k] == S_READY && hit[k] && i_seg_first) begin
        eat_any = 1'b1;
        eat_idx = IDX_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
      reject[k] = (pos_x[k] == '0) || (pos_x[k] > MAX_X) ||
                  (pos_y[k] == '0) || (pos_y[k] > MAX_Y);
      for (int unsigned j = 0; j < NUM_ITEMS; j++) begin
        if (j != k && placed[j] && pos_x[j] == pos_x[k] && pos_y[j] == pos_y[k])
          reject[k] = 1'b1;
      end
    end
    step = draw_taken || i_entropy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_x    <= X_BITS'(1);
      lfsr_y    <= Y_BITS'(1);
      o_eat     <= 1'b0;
      o_eat_idx <= '0;
      for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
        state[k] <= S_DRAW;
        pos_x[k] <= '0;
        pos_y[k] <= '0;
      end
    end else begin
      if (step) begin
        lfsr_x <= lfsr_x[0] ? ((lfsr_x >> 1) ^ TAP_X) : (lfsr_x >> 1);
        lfsr_y <= lfsr_y[0] ? ((lfsr_y >> 1) ^ TAP_Y) : (lfsr_y >> 1);
      end
      o_eat     <= eat_any;
      o_eat_idx <= eat_idx;
      for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
        if (!active[k]) begin
          state[k] <= S_IDLE;
        end else begin
          case (state[k])
            S_IDLE: state[k] <= S_DRAW;
            S_DRAW:
              if (grant[k]) begin
                pos_x[k] <= lfsr_x;
                pos_y[k] <= lfsr_y;
                state[k] <= S_CHECK;
              end
            S_CHECK: state[k] <= reject[k] ? S_DRAW : S_WAIT;
            // The opening head beat is already a test beat, including a one-beat snake
            S_WAIT:
              if (i_seg_valid && i_seg_first) begin
                if (hit[k])          state[k] <= S_DRAW;
                else if (i_seg_last) state[k] <= S_READY;
                else                 state[k] <= S_TEST;
              end
            S_TEST:
              if (hit[k])                        state[k] <= S_DRAW;
              else if (i_seg_valid && i_seg_last) state[k] <= S_READY;
            S_READY: if (hit[k]) state[k] <= S_DRAW;
            default: state[k] <= S_DRAW;
          endcase
        end
      end
    end
  end

  always_comb begin
    o_item_x = '0;
    o_item_y = '0;
    o_ready  = '0;
    for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
      o_item_x[k*X_BITS +: X_BITS] = pos_x[k];
      o_item_y[k*Y_BITS +: Y_BITS] = pos_y[k];
      o_ready[k]                   = (state[k] == S_READY);
    end
  end

endmodule

// File: tb/tb_item_spawner.sv
// Directed bench for item_spawner: default-size instance for placement, eat, shrink and
// forced-draw cases, plus a tiny-field instance for the single-free-cell search.
module tb_item_spawner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  active;
  logic        entropy, seg_valid, seg_first, seg_last;
  logic [4:0]  seg_x;
  logic [3:0]  seg_y;
  logic [19:0] item_x;
  logic [15:0] item_y;
  logic [3:0]  ready;
  logic        eat;
  logic [1:0]  eat_idx;

  logic        s_active, s_valid, s_first, s_last;
  logic [2:0]  s_x;
  logic [1:0]  s_y;
  logic [2:0]  s_item_x;
  logic [1:0]  s_item_y;
  logic        s_ready, s_eat, s_eat_idx;

  item_spawner #(.NUM_ITEMS(4), .X_BITS(5), .Y_BITS(4), .FIELD_W(20), .FIELD_H(12)) dut (
    .clk(clk), .rst_n(rst_n), .i_active(active), .i_entropy(entropy),
    .i_seg_valid(seg_valid), .i_seg_first(seg_first), .i_seg_last(seg_last),
    .i_seg_x(seg_x), .i_seg_y(seg_y), .o_item_x(item_x), .o_item_y(item_y),
    .o_ready(ready), .o_eat(eat), .o_eat_idx(eat_idx)
  );

  item_spawner #(.NUM_ITEMS(1), .X_BITS(3), .Y_BITS(2), .FIELD_W(6), .FIELD_H(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_active(s_active), .i_entropy(1'b0),
    .i_seg_valid(s_valid), .i_seg_first(s_first), .i_seg_last(s_last),
    .i_seg_x(s_x), .i_seg_y(s_y), .o_item_x(s_item_x), .o_item_y(s_item_y),
    .o_ready(s_ready), .o_eat(s_eat), .o_eat_idx(s_eat_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] snk_x[$];
  logic [3:0] snk_y[$];
  logic [2:0] ss_x[$];
  logic [1:0] ss_y[$];

  typedef struct {
    logic [2:0] act;
    int         passes;
    logic [3:0] exp_ready;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_snake1(input logic [4:0] x, input logic [3:0] y);
    snk_x.delete(); snk_y.delete();
    snk_x.push_back(x); snk_y.push_back(y);
  endtask

  task automatic run_pass(input int gap);
    repeat (gap) @(negedge clk);
    for (int i = 0; i < snk_x.size(); i++) begin
      @(negedge clk);
      seg_valid = 1'b1;
      seg_first = (i == 0);
      seg_last  = (i == snk_x.size() - 1);
      seg_x     = snk_x[i];
      seg_y     = snk_y[i];
    end
    @(negedge clk);
    seg_valid = 1'b0; seg_first = 1'b0; seg_last = 1'b0;
  endtask

  task automatic s_pass(input int gap);
    repeat (gap) @(negedge clk);
    for (int i = 0; i < ss_x.size(); i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_first = (i == 0);
      s_last  = (i == ss_x.size() - 1);
      s_x     = ss_x[i];
      s_y     = ss_y[i];
    end
    @(negedge clk);
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  task automatic check_items(input logic [3:0] mask);
    logic [4:0] x, xj;
    logic [3:0] y, yj;
    logic       on;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        x = item_x[k*5 +: 5];
        y = item_y[k*4 +: 4];
        chk($sformatf("item%0d_in_bounds", k), 32'(x >= 1 && x <= 20 && y >= 1 && y <= 12), 1);
        on = 1'b0;
        for (int i = 0; i < snk_x.size(); i++)
          if (snk_x[i] == x && snk_y[i] == y) on = 1'b1;
        chk($sformatf("item%0d_off_snake", k), 32'(on), 0);
        for (int j = k + 1; j < 4; j++) begin
          if (mask[j]) begin
            xj = item_x[j*5 +: 5];
            yj = item_y[j*4 +: 4];
            chk($sformatf("items%0d%0d_distinct", k, j), 32'(x == xj && y == yj), 0);
          end
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{act: 3'd1, passes: 2, exp_ready: 4'b0001};
    tbl[1] = '{act: 3'd0, passes: 1, exp_ready: 4'b0000};
    tbl[2] = '{act: 3'd2, passes: 3, exp_ready: 4'b0011};
    tbl[3] = '{act: 3'd4, passes: 4, exp_ready: 4'b1111};
    tbl[4] = '{act: 3'd3, passes: 1, exp_ready: 4'b0111};
    tbl[5] = '{act: 3'd4, passes: 3, exp_ready: 4'b1111};

    rst_n = 1'b0; active = 3'd1; entropy = 1'b0;
    seg_valid = 1'b0; seg_first = 1'b0; seg_last = 1'b0; seg_x = '0; seg_y = '0;
    s_active = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_x = '0; s_y = '0;
    set_snake1(5'd3, 4'd3);

    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_eat", eat, 0);
    chk("reset_eat_idx", eat_idx, 0);
    chk("reset_item_x", item_x, 0);
    chk("reset_item_y", item_y, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      active = tbl[v].act;
      for (int p = 0; p < tbl[v].passes; p++) run_pass(30);
      chk($sformatf("tbl%0d_ready", v), ready, tbl[v].exp_ready);
      check_items(tbl[v].exp_ready);
    end

    // Shrink 4 -> 2 in the middle of a three-beat pass
    snk_x.delete(); snk_y.delete();
    for (int i = 0; i < 3; i++) begin snk_x.push_back(5'd3); snk_y.push_back(4'd3); end
    @(negedge clk); seg_valid = 1'b1; seg_first = 1'b1; seg_last = 1'b0; seg_x = 5'd3; seg_y = 4'd3;
    @(negedge clk); seg_first = 1'b0; active = 3'd2;
    @(negedge clk);
    chk("shrink_ready_next_cycle", ready, 4'b0011);
    seg_last = 1'b1;
    @(negedge clk);
    seg_valid = 1'b0; seg_last = 1'b0;
    chk("shrink_ready_after_pass", ready, 4'b0011);
    check_items(4'b0011);

    // Forced out-of-bounds draw keeps slot 0 cycling through redraws
    set_snake1(5'd3, 4'd3);
    active = 3'd0;
    repeat (2) @(negedge clk);
    force dut.lfsr_x = 5'd31;
    active = 3'd1;
    run_pass(10);
    chk("oob_not_ready_1", ready, 0);
    chk("oob_candidate_x", item_x[4:0], 31);
    run_pass(10);
    chk("oob_not_ready_2", ready, 0);
    release dut.lfsr_x;
    for (int p = 0; p < 4 && !ready[0]; p++) run_pass(30);
    chk("oob_recovered_ready", ready, 4'b0001);
    check_items(4'b0001);

    // Place slot 0 at (7,5) and let the head run onto it
    active = 3'd0;
    repeat (2) @(negedge clk);
    force dut.lfsr_x = 5'd7;
    force dut.lfsr_y = 4'd5;
    active = 3'd1;
    repeat (3) @(negedge clk);
    release dut.lfsr_x;
    release dut.lfsr_y;
    run_pass(2);
    chk("eat_setup_ready", ready, 4'b0001);
    chk("eat_setup_x", item_x[4:0], 7);
    chk("eat_setup_y", item_y[3:0], 5);
    snk_x.delete(); snk_y.delete();
    snk_x.push_back(5'd7); snk_y.push_back(4'd5);
    snk_x.push_back(5'd3); snk_y.push_back(4'd3);
    @(negedge clk); seg_valid = 1'b1; seg_first = 1'b1; seg_last = 1'b0; seg_x = 5'd7; seg_y = 4'd5;
    @(negedge clk);
    chk("eat_pulse", eat, 1);
    chk("eat_idx", eat_idx, 0);
    chk("eat_ready_dropped", ready, 0);
    seg_first = 1'b0; seg_last = 1'b1; seg_x = 5'd3; seg_y = 4'd3;
    @(negedge clk);
    chk("eat_single_cycle", eat, 0);
    seg_valid = 1'b0; seg_last = 1'b0;
    for (int p = 0; p < 4 && !ready[0]; p++) run_pass(20);
    chk("eat_new_item_ready", ready, 4'b0001);
    check_items(4'b0001);

    // Tiny 6x3 field: snake on every cell except (4,2)
    for (int yy = 1; yy <= 3; yy++)
      for (int xx = 1; xx <= 6; xx++)
        if (!(xx == 4 && yy == 2)) begin
          ss_x.push_back(3'(xx));
          ss_y.push_back(2'(yy));
        end
    for (int p = 0; p < 40 && !s_ready; p++) s_pass(3);
    chk("free_cell_ready", 32'(s_ready), 1);
    chk("free_cell_x", 32'(s_item_x), 4);
    chk("free_cell_y", 32'(s_item_y), 2);
    chk("free_cell_no_eat", 32'(s_eat), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
